axi_rd_data_return_arbiter: RTL
===============================

Name: axi_rd_data_return_arbiter

Overview:
- Sits between NUM_SLV per-slave asynchronous read-data FIFOs (37-bit entries, non-show-ahead, data valid one cycle after rd_en) and a single AXI4 master R channel.
- Schedules FIFO pops round-robin with burst locking: once a slave is granted, it owns the R channel until its rlast beat has been popped.
- Handles the FIFO read latency with a 2-entry output buffer, so throughput is one beat per clock.

Parameters:
- NUM_SLV, 4, number of read-data FIFOs/requesters (2..8).
- DATA_WIDTH, 32, rdata width.
- ID_WIDTH, 2, rid width.
- ENTRY_W, ID_WIDTH+2+DATA_WIDTH+1 (=37), FIFO entry width. Layout MSB→LSB: {rid, rresp[1:0], rdata, rlast}.
- SEL_W, $clog2(NUM_SLV), width of the slave index.

Ports:
- clk  in  1  system clock; FIFO read side and R channel are both in this domain.
- rst  in  1  synchronous, active-high reset.
- fifo_rd_data  in  NUM_SLV*ENTRY_W  concatenated FIFO outputs; slave i occupies [i*ENTRY_W +: ENTRY_W].
- fifo_rd_empty  in  NUM_SLV  per-FIFO empty flag.
- fifo_rd_en  out  NUM_SLV  per-FIFO pop; at most one bit high per cycle.
- m_rid  out  ID_WIDTH  R channel ID.
- m_rresp  out  2  R channel response.
- m_rdata  out  DATA_WIDTH  R channel data.
- m_rlast  out  1  R channel last.
- m_rsel  out  SEL_W  index of the slave that sourced the current beat.
- m_rvalid  out  1  R channel valid.
- m_rready  in  1  R channel ready.
- busy  out  1  high when the state is BURST, the buffer is non-empty, or a read is in flight.

Behaviour:
- Reset (clk edge with rst=1):
  - state=ARB; RR pointer=NUM_SLV-1, so slave 0 has first priority.
  - Buffer count=0; inflight=0; fifo_rd_en=0; m_rvalid=0; m_r* data fields=0; m_rsel=0; busy=0.
  - An entry popped before reset but not yet delivered is discarded; no reads are issued during reset.
- FSM ARB:
  - Scans requesters (~fifo_rd_empty) starting at pointer+1, wrapping modulo NUM_SLV.
  - On a hit: registers grant=winner and pointer=winner, then goes to BURST. No pop is issued in ARB.
  - With no requesters it stays in ARB.
- FSM BURST:
  - Pops only the granted FIFO.
  - Moves to ARB on the clock edge where the returning entry (inflight=1) has rlast=1.
  - No switch on empty: if the granted FIFO is empty mid-burst, the block waits in BURST indefinitely.
- Pop rule (combinational):
  - fifo_rd_en[grant] = (state==BURST) & ~fifo_rd_empty[grant] & ~(inflight & ret_last) & (count + inflight − pop_out < 2).
  - ret_last = rlast bit of fifo_rd_data[grant] while inflight=1.
  - pop_out = m_rvalid & m_rready.
  - inflight is registered as fifo_rd_en from the previous cycle.
- Capture:
  - When inflight=1, fifo_rd_data[grant] is written to the buffer tail together with grant as m_rsel. This happens at the same edge as any pop_out.
  - count is in 0..2; overflow is impossible by construction and an assertion must check it.
- Output:
  - Buffer head drives m_*; m_rvalid = (count≠0).
  - Beat order equals FIFO pop order.
  - A new grant may start popping while the previous burst's beats are still draining.
- Latency: first FIFO non-empty sampled in ARB at edge t0 → state=BURST and rd_en high in cycle t1 → data captured at edge t2 → m_rvalid=1 in cycle t2+.
- Throughput: with m_rready held high and the FIFO non-empty, one beat per clock.
- Round-robin fairness: after a burst from slave k, slave k has lowest priority in the next ARB.
- Back-pressure: m_rready low freezes the buffer head; at most 2 entries are buffered, and rd_en stays low until space frees.
- Simultaneous pop_out and capture with count=2 is legal only because the pop rule already reserved the slot.
- Back-to-back with no gap between bursts is not required: there is one ARB cycle between a burst's last pop and the next grant.

Test Plan:
1. Slave 0 holds a 4-beat burst (rdata 0xA0..0xA3, rid=1, rlast on beat 3); m_rready=1 → rd_en[0] high for cycles t1..t4; four beats with m_rsel=0 and m_rvalid contiguous; m_rlast only on 0xA3; return to ARB.
2. Slaves 1 and 2 each hold two 2-beat bursts → grant order 1,2,1,2; no interleaving of beats inside a burst.
3. 8-beat burst with m_rready=0 for 5 cycles mid-burst → count saturates at 2, rd_en low throughout the stall; no beat lost or duplicated; data resumes in order.
4. Slave 3 FIFO goes empty after beat 1 of 4 for 6 cycles while slave 0 is non-empty → grant stays 3; slave 0 is served only after 3's rlast.
5. rst asserted for 1 cycle in mid-burst with 1 beat buffered → next cycle: m_rvalid=0, fifo_rd_en=0, state ARB; slave 0 is granted first if non-empty.
6. All FIFOs empty → fifo_rd_en=0, m_rvalid=0, busy=0 for 20 cycles.

Source files
------------

// File: rtl/axi_rd_data_return_arbiter.sv
// Round-robin, burst-locked return path from per-slave read-data FIFOs onto one AXI4 R channel.
// A 2-entry output buffer hides the one-cycle FIFO read latency.
module axi_rd_data_return_arbiter #(
  parameter int NUM_SLV    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 2,
  parameter int ENTRY_W    = ID_WIDTH + 2 + DATA_WIDTH + 1,
  parameter int SEL_W      = $clog2(NUM_SLV)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_SLV*ENTRY_W-1:0] fifo_rd_data,
  input  logic [NUM_SLV-1:0]         fifo_rd_empty,
  output logic [NUM_SLV-1:0]         fifo_rd_en,
  output logic [ID_WIDTH-1:0]        m_rid,
  output logic [1:0]                 m_rresp,
  output logic [DATA_WIDTH-1:0]      m_rdata,
  output logic                       m_rlast,
  output logic [SEL_W-1:0]           m_rsel,
  output logic                       m_rvalid,
  input  logic                       m_rready,
  output logic                       busy
);

  localparam logic [0:0] StArb   = 1'b0;
  localparam logic [0:0] StBurst = 1'b1;

  logic [ENTRY_W-1:0] slv_entry [NUM_SLV];

  for (genvar g = 0; g < NUM_SLV; g++) begin : g_split
    assign slv_entry[g] = fifo_rd_data[g*ENTRY_W +: ENTRY_W];
  end

  logic [0:0]         state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [SEL_W-1:0]   grant_q, grant_d;
  logic               inflight_q;
  logic [1:0]         count_q, count_d;
  logic [ENTRY_W-1:0] buf_q [2];
  logic [ENTRY_W-1:0] buf_d [2];
  logic [SEL_W-1:0]   sel_q [2];
  logic [SEL_W-1:0]   sel_d [2];

  logic [ENTRY_W-1:0] ret_entry;
  logic               ret_last;
  logic               pop_out;
  logic [2:0]         occ;
  logic               pop_ok;
  logic               wr_hi;

  logic [NUM_SLV-1:0] req;
  logic               found;
  logic [SEL_W-1:0]   winner;
  logic [SEL_W-1:0]   idx;

  assign ret_entry = slv_entry[grant_q];
  assign ret_last  = inflight_q & ret_entry[0];
  assign m_rvalid  = (count_q != 2'd0);
  assign pop_out   = m_rvalid & m_rready;
  // Occupancy after this edge if a pop were not issued; a new pop needs a free slot beyond it.
  assign occ       = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop_out};
  assign pop_ok    = ~rst & (state_q == StBurst) & ~fifo_rd_empty[grant_q] & ~ret_last &
                     (occ < 3'd2);

  always_comb begin
    fifo_rd_en = '0;
    if (pop_ok) fifo_rd_en[grant_q] = 1'b1;
  end

  // Scan from the slot after the last winner so it gets lowest priority.
  always_comb begin
    req    = ~fifo_rd_empty;
    found  = 1'b0;
    winner = ptr_q;
    idx    = '0;
    for (int i = 1; i <= NUM_SLV; i++) begin
      idx = SEL_W'((int'(ptr_q) + i) % NUM_SLV);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    case (state_q)
      StArb: begin
        if (found) begin
          grant_d = winner;
          ptr_d   = winner;
          state_d = StBurst;
        end
      end
      StBurst: begin
        if (ret_last) state_d = StArb;
      end
    endcase
  end

  always_comb begin
    buf_d   = buf_q;
    sel_d   = sel_q;
    count_d = count_q + {1'b0, inflight_q} - {1'b0, pop_out};
    wr_hi   = ((count_q - {1'b0, pop_out}) != 2'd0);
    if (pop_out) begin
      buf_d[0] = buf_q[1];
      sel_d[0] = sel_q[1];
    end
    if (inflight_q) begin
      buf_d[wr_hi] = ret_entry;
      sel_d[wr_hi] = grant_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StArb;
      ptr_q      <= SEL_W'(NUM_SLV - 1);
      grant_q    <= '0;
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      sel_q[0]   <= '0;
      sel_q[1]   <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      inflight_q <= pop_ok;
      count_q    <= count_d;
      buf_q      <= buf_d;
      sel_q      <= sel_d;
    end
  end

  assign m_rid   = buf_q[0][ENTRY_W-1 -: ID_WIDTH];
  assign m_rresp = buf_q[0][DATA_WIDTH+2 -: 2];
  assign m_rdata = buf_q[0][DATA_WIDTH:1];
  assign m_rlast = buf_q[0][0];
  assign m_rsel  = sel_q[0];
  assign busy    = (state_q == StBurst) | (count_q != 2'd0) | inflight_q;

  count_overflow_a: assert property (@(posedge clk) disable iff (rst)
    (count_q <= 2'd2) && !(inflight_q && !pop_out && (count_q == 2'd2)));

endmodule
